// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and emits them one bit
// per clock on j, gapless across words. Define SER_PARITY_EN to append an even-parity bit.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             j,
  output logic             j_valid,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NBITS - 1);
`ifdef SER_PARITY_EN
  localparam logic [CntW-1:0] CntData = CntW'(WIDTH - 1);
`endif

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             j_q, j_d;
  logic             last;
  logic             transfer;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  assign last = (state_q == StShift) && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      j_q     <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      j_q     <= j_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The first bit goes straight to j on load; sreg holds the remaining bits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    j_d      = 1'b0;
    transfer = din_valid & din_ready;
`ifdef SER_PARITY_EN
    par_d    = par_q;
`endif
    if (transfer) begin
      state_d = StShift;
      cnt_d   = '0;
      j_d     = out_bit(din);
      sreg_d  = shift_out(din);
`ifdef SER_PARITY_EN
      par_d   = ^din;
`endif
    end else begin
      unique case (state_q)
        StShift: begin
          if (!last) begin
            cnt_d  = cnt_q + CntW'(1);
            j_d    = out_bit(sreg_q);
            sreg_d = shift_out(sreg_q);
`ifdef SER_PARITY_EN
            if (cnt_q == CntData) j_d = par_q;
`endif
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    din_ready = (state_q == StIdle) | last;
    j         = j_q;
    j_valid   = (state_q == StShift);
    busy      = (state_q == StShift);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance for most scenarios, LSB-first instance
// for bit-order checks. Expectations follow SER_PARITY_EN when it is defined.
module tb_bit_serializer;
`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_m = '0, din_l = '0;
  logic       valid_m = 1'b0, valid_l = 1'b0;
  logic       ready_m, j_m, jv_m, busy_m;
  logic       ready_l, j_l, jv_l, busy_l;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(valid_m),
    .din_ready(ready_m), .j(j_m), .j_valid(jv_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(valid_l),
    .din_ready(ready_l), .j(j_l), .j_valid(jv_l), .busy(busy_l)
  );

  task automatic test_reset();
    #3;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_msb got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
    checks++;
    if ({j_l, jv_l, busy_l, ready_l} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_lsb got=%b exp=0001", {j_l, jv_l, busy_l, ready_l});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [NB-1:0] e;
`ifdef SER_PARITY_EN
    e = 9'b1001_0000_0;
`else
    e = 8'b1001_0000;
`endif
    din_m = 8'h90; valid_m = 1'b1;
    checks++;
    if (ready_m !== 1'b1) begin
      failures++; $display("FAIL single_ready0 got=%b exp=1", ready_m);
    end
    @(posedge clk); #1;
    valid_m = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({j_m, jv_m, busy_m, ready_m} !== {e[NB-c], 1'b1, 1'b1, 1'(c == NB)}) begin
        failures++;
        $display("FAIL single cycle=%0d got=%b exp=%b", c, {j_m, jv_m, busy_m, ready_m},
                 {e[NB-c], 1'b1, 1'b1, 1'(c == NB)});
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL single_idle got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
  endtask

  task automatic test_back_to_back();
    logic [2*NB-1:0] e;
`ifdef SER_PARITY_EN
    e = 18'b10100101_0_00111100_0;
`else
    e = 16'b10100101_00111100;
`endif
    din_m = 8'hA5; valid_m = 1'b1;
    checks++;
    if (ready_m !== 1'b1) begin
      failures++; $display("FAIL b2b_ready0 got=%b exp=1", ready_m);
    end
    for (int c = 1; c <= 2 * NB; c++) begin
      @(posedge clk); #1;
      if (c == 1) din_m = 8'h3C;
      if (c == NB + 1) valid_m = 1'b0;
      checks++;
      if ({j_m, jv_m, busy_m, ready_m} !==
          {e[2*NB-c], 1'b1, 1'b1, 1'(c == NB || c == 2 * NB)}) begin
        failures++;
        $display("FAIL b2b cycle=%0d got=%b exp=%b", c, {j_m, jv_m, busy_m, ready_m},
                 {e[2*NB-c], 1'b1, 1'b1, 1'(c == NB || c == 2 * NB)});
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL b2b_idle got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
  endtask

  task automatic test_stall();
    logic [NB-1:0] e;
`ifdef SER_PARITY_EN
    e = 9'b00111100_0;
`else
    e = 8'b00111100;
`endif
    din_m = 8'h3C; valid_m = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({j_m, jv_m, busy_m, ready_m} !== {e[NB-c], 1'b1, 1'b1, 1'(c == NB)}) begin
        failures++;
        $display("FAIL stall cycle=%0d got=%b exp=%b", c, {j_m, jv_m, busy_m, ready_m},
                 {e[NB-c], 1'b1, 1'b1, 1'(c == NB)});
      end
      if (c >= 2 && c < NB) begin
        valid_m = 1'b1;
        din_m   = c[0] ? 8'hFF : 8'h00;
      end
      if (c == NB) din_m = 8'h81;
    end
    @(posedge clk); #1;
    valid_m = 1'b0;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b1110) begin
      failures++; $display("FAIL stall_newword got=%b exp=1110", {j_m, jv_m, busy_m, ready_m});
    end
    @(posedge clk); #1;
    checks++;
    if ({j_m, jv_m} !== 2'b01) begin
      failures++; $display("FAIL stall_newbit1 got=%b exp=01", {j_m, jv_m});
    end
    repeat (NB - 1) @(posedge clk);
    #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL stall_idle got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
  endtask

  task automatic test_reset_midword();
    din_m = 8'hFF; valid_m = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b1110) begin
      failures++; $display("FAIL rst_bit3 got=%b exp=1110", {j_m, jv_m, busy_m, ready_m});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL rst_async got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
    valid_m = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL rst_ignore got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
    valid_m = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL rst_noresume got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
    // Reassert, then offer a word right at release: the first edge with rst=1 must take it.
    rst = 1'b0;
    #1;
    din_m = 8'h80; valid_m = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b1110) begin
      failures++; $display("FAIL rst_release got=%b exp=1110", {j_m, jv_m, busy_m, ready_m});
    end
    repeat (NB) @(posedge clk);
    #1;
    checks++;
    if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
      failures++; $display("FAIL rst_drain got=%b exp=0001", {j_m, jv_m, busy_m, ready_m});
    end
  endtask

  task automatic test_lsb_first();
    logic [NB-1:0] e;
`ifdef SER_PARITY_EN
    e = 9'b1001_0000_0;
`else
    e = 8'b1001_0000;
`endif
    din_l = 8'h09; valid_l = 1'b1;
    @(posedge clk); #1;
    valid_l = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({j_l, jv_l, busy_l, ready_l} !== {e[NB-c], 1'b1, 1'b1, 1'(c == NB)}) begin
        failures++;
        $display("FAIL lsb cycle=%0d got=%b exp=%b", c, {j_l, jv_l, busy_l, ready_l},
                 {e[NB-c], 1'b1, 1'b1, 1'(c == NB)});
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({j_l, jv_l, busy_l, ready_l} !== 4'b0001) begin
      failures++; $display("FAIL lsb_idle got=%b exp=0001", {j_l, jv_l, busy_l, ready_l});
    end
  endtask

  task automatic test_parity();
    logic [7:0]    words [2];
    logic [NB-1:0] e     [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
`ifdef SER_PARITY_EN
    e[0] = 9'b00000111_1;
    e[1] = 9'b00000011_0;
`else
    e[0] = 8'b00000111;
    e[1] = 8'b00000011;
`endif
    for (int w = 0; w < 2; w++) begin
      din_m = words[w]; valid_m = 1'b1;
      @(posedge clk); #1;
      valid_m = 1'b0;
      for (int c = 1; c <= NB; c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        checks++;
        if ({j_m, jv_m} !== {e[w][NB-c], 1'b1}) begin
          failures++;
          $display("FAIL parity word=%0d cycle=%0d got=%b exp=%b", w, c, {j_m, jv_m},
                   {e[w][NB-c], 1'b1});
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({j_m, jv_m, busy_m, ready_m} !== 4'b0001) begin
        failures++;
        $display("FAIL parity_idle word=%0d got=%b exp=0001", w, {j_m, jv_m, busy_m, ready_m});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midword();
    test_lsb_first();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder stage for the serial sequence-detector blocks.
- Accepts WIDTH-bit parallel words over a valid/ready handshake and shifts them out one bit per clock on the serial line j.
- j_valid qualifies each serial bit.
- Back-to-back words are emitted with no idle gap; between words j is held at 0.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range 2..32.
- LSB_FIRST, 0: 0 = emit bit WIDTH-1 first; 1 = emit bit 0 first.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block accepts din this cycle.
- j  output  1  serial data bit; registered.
- j_valid  output  1  j carries a word bit (or parity bit); registered.
- busy  output  1  a word is in the shift register or being emitted.

Behaviour:
- Transfer: a word is accepted on a rising clk edge where din_valid=1 and din_ready=1. din_valid may stay high across words. din may change freely when no transfer occurs.
- State machine (registered):
  - IDLE: j=0, j_valid=0, busy=0.
  - SHIFT: j_valid=1, busy=1, bit counter cnt counts 0..NBITS-1.
  - NBITS = WIDTH, or WIDTH+1 with the optional feature.
- Transitions:
  - IDLE -> SHIFT on transfer; cnt=0.
  - SHIFT, cnt<NBITS-1: advance one bit per clk, cnt+1.
  - SHIFT, cnt=NBITS-1, transfer: reload, stay in SHIFT, cnt=0 (gapless).
  - SHIFT, cnt=NBITS-1, no transfer: -> IDLE.
- din_ready = (state==IDLE) | (state==SHIFT & cnt==NBITS-1). It is combinational from registers only and never depends on din_valid.
- Latency:
  - The first bit of a word is on j in the cycle after the accepting edge.
  - Bit k of the emission order is on j k+1 cycles after acceptance.
  - j_valid stays high for exactly NBITS consecutive cycles per word.
- Order:
  - LSB_FIRST=0: din[WIDTH-1], din[WIDTH-2], ..., din[0].
  - LSB_FIRST=1: din[0] .. din[WIDTH-1].
- Reset (rst=0, async, takes effect immediately):
  - state=IDLE, cnt=0, shift register=0, j=0, j_valid=0, busy=0.
  - din_ready reads 1.
  - Transfers are ignored while rst=0.
  - Reset mid-word discards the remaining bits; no partial word resumes after release.
- Release: the first transfer is possible on the first rising edge with rst=1.
- Width rules: cnt is clog2(WIDTH+1) bits. The shift register is WIDTH bits and shifts toward the output end, filling with 0.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one even-parity bit (XOR of all WIDTH bits of the accepted word) is emitted with j_valid=1.
  - NBITS = WIDTH+1; din_ready rises during the parity-bit cycle.
- Not defined: NBITS = WIDTH, no parity logic is present, and behaviour is exactly as above.

Test Plan:
- Single word, WIDTH=8, LSB_FIRST=0: din=8'h90 accepted at edge 0 -> j = 1,0,0,1,0,0,0,0 on cycles 1..8 with j_valid=1; cycle 9 j=0, j_valid=0, busy=0, din_ready=1.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> j_valid high for 16 consecutive cycles; j = 10100101 00111100; din_ready=1 only in cycles 0, 8 and 16.
- Stall: din_valid=1 from cycle 2 to 7 of a word in flight -> din_ready=0 and no transfer; new word accepted at the edge ending cycle 8; din changes during the stall have no effect on j.
- Reset mid-word: rst=0 asynchronously during bit 3 of 8'hFF -> j, j_valid, busy drop to 0 without waiting for clk; after release j stays 0 until a new transfer.
- LSB_FIRST=1, din=8'h09 -> j = 1,0,0,1,0,0,0,0. Combined with the detector this yields exactly one w pulse for pattern 10010.
- SER_PARITY_EN defined: din=8'h07 -> 8 data bits then parity bit 1; j_valid high 9 cycles. din=8'h03 -> parity bit 0.
